sram_axi_bridge_mp: RTL
=======================

# sram_axi_bridge_mp

Parametrised successor to the two-port SRAM-to-AXI bridge in the CPU top. It arbitrates NPORT SRAM-like masters onto one AXI3 master port. Masters are IF, EXE/MEM, and future I/D-cache refill ports. It supports INCR burst reads, up to MAX_RD outstanding reads per port, one outstanding write, and read-after-write address hazard blocking.

## Interface
- NPORT, 2: number of SRAM-like ports; port i uses AXI ID i; requires NPORT ≤ 16.
- MAX_RD, 2: maximum outstanding read transactions per port, in 1..7.
- aclk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- p_req  in  NPORT  request valid, one bit per port.
- p_wr  in  NPORT  1 = write, 0 = read.
- p_size  in  2*NPORT  0/1/2 = byte/half/word.
- p_addr  in  32*NPORT  byte address.
- p_len  in  8*NPORT  read burst beats minus 1; ignored for writes.
- p_wstrb  in  4*NPORT  write byte strobes.
- p_wdata  in  32*NPORT  write data.
- p_addr_ok  out  NPORT  request accepted this cycle.
- p_data_ok  out  NPORT  read beat valid, or write response.
- p_rlast  out  NPORT  last read beat.
- p_rdata  out  32*NPORT  read data. Every port sees the current rdata.
- AR channel  out: arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0], arvalid. In: arready.
- R channel  in: rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid. Out: rready.
- AW channel  out: awid[3:0], awaddr[31:0], awlen[7:0], awsize[2:0], awburst[1:0], awlock[1:0], awcache[3:0], awprot[2:0], awvalid. In: awready.
- W channel  out: wid[3:0], wdata[31:0], wstrb[3:0], wlast, wvalid. In: wready.
- B channel  in: bid[3:0], bresp[1:0], bvalid. Out: bready.

## Operation
- Constant outputs: arburst = awburst = 2'b01; arlock = awlock = 0; arcache = awcache = 0; arprot = awprot = 0; awlen = 0; wlast = 1; rready = 1.
- Read arbiter: round-robin over ports with p_req & ~p_wr.
  - A port is eligible when all of these hold:
    - rd_cnt[i] < MAX_RD;
    - AR register empty, or being emptied this cycle by arvalid & arready;
    - no hazard.
  - Hazard: write pending and p_addr[31:2] == pending waddr[31:2].
  - On acceptance, the AR register loads: arid = i, araddr, arlen = p_len, arsize = {0, p_size}. Then p_addr_ok[i] = 1 and rd_cnt[i] increments.
  - arvalid holds until arready.
- The read round-robin pointer moves to the granted port + 1 on acceptance only.
- R routing: for rvalid with rid < NPORT, p_data_ok[rid] = 1 and p_rlast[rid] = rlast.
  - rd_cnt[rid] decrements on the rlast beat.
  - If one port's accept and last beat coincide, its count is unchanged.
  - Beats with rid ≥ NPORT are consumed and dropped.
- Write FSM states: W_IDLE, W_SEND, W_RESP.
  - W_IDLE: round-robin over ports with p_req & p_wr. The grant gives p_addr_ok, latches awid = wid = i, awaddr, awsize, wdata, wstrb, and the write port, then goes to W_SEND with awvalid = wvalid = 1.
  - W_SEND: awvalid and wvalid each clear independently on their own handshake. When both are done, go to W_RESP. Both handshakes in the first cycle goes directly to W_RESP.
  - W_RESP: bready = 1 except when rvalid & rid == write port.
  - On bvalid & bready: p_data_ok[write port] = 1, return to W_IDLE. A new write may be granted the following cycle, not the same cycle.
- Per-port constraint: p_addr_ok and p_data_ok are each at most one-hot per port per cycle. A port has at most one of read or write accepted per cycle, because its p_wr selects which arbiter sees it.
- rresp and bresp are ignored.
- Reset: all counters 0, pointers 0, FSM W_IDLE. Every output is 0 except the constants listed above, including rready = 1.
  - A reset mid-transaction abandons all in-flight AXI traffic.
  - Beats that arrive after reset and before a new read decrement nothing below 0: rd_cnt saturates at 0.

## Timing
- p_addr_ok is combinational from p_req, arbiter state, counters and arready, in the same cycle as the request.
- arvalid rises the cycle after acceptance. Back-to-back reads issue every cycle while arready = 1.
- p_data_ok and p_rdata are combinational from rvalid and rdata: zero-cycle pass-through.
- Minimum read latency is 2 cycles: req in cycle 0, arvalid in cycle 1 with slave rvalid in cycle 2, p_data_ok in cycle 2.
- Minimum write latency is 3 cycles: accept in cycle 0, AW/W in cycle 1, bvalid in cycle 2 seen as p_data_ok in cycle 2. The next write is accepted in cycle 3.
- A write retires in the same cycle as its B handshake, so the hazard clears the cycle after bvalid & bready.

## Test plan
- Single-word read: port 0 reads 0x1c000000 with size 2 and len 0. Expect arvalid next cycle with arid = 0, arsize = 2, arlen = 0. Slave rdata 0xdeadbeef with rlast gives p_data_ok[0] = 1, p_rlast[0] = 1, p_rdata = 0xdeadbeef.
- Burst and credits (NPORT = 2, MAX_RD = 2): port 1 issues two len = 3 reads. A third is refused (p_addr_ok[1] = 0) until the 4th beat with rlast of the first burst arrives; then it is accepted in that same cycle.
- Round-robin: ports 0 and 1 read every cycle with arready = 1. Grants alternate 0, 1, 0, 1, and arid follows the same sequence.
- RAW hazard: port 1 writes 0x100 with wstrb 0xf while the slave withholds bvalid.
  - A port 0 read to 0x102 is blocked.
  - A read to 0x104 is accepted.
  - After bvalid, the 0x102 read is accepted the following cycle.
- Write channel skew: awready rises in cycle 1 and wready in cycle 3. awvalid drops after cycle 1, wvalid after cycle 3, and bready is asserted from cycle 4.
- Collision and reset:
  - rvalid with rid = 1 in the same cycle as bvalid for port 1 gives bready = 0 that cycle. p_data_ok[1] reflects only the read beat, and the B response is taken the next cycle.
  - Asserting reset mid-burst returns all outputs and counters to their reset values on the next edge.

Source files
------------

// File: rtl/sram_axi_bridge_mp.sv
// Bridges NPORT SRAM-like masters onto one AXI3 master: round-robin reads with per-port
// credits, a single outstanding write, and read-after-write word-address hazard blocking.
module sram_axi_bridge_mp #(
  parameter int unsigned NPORT  = 2,
  parameter int unsigned MAX_RD = 2
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic [NPORT-1:0]      p_req,
  input  logic [NPORT-1:0]      p_wr,
  input  logic [2*NPORT-1:0]    p_size,
  input  logic [32*NPORT-1:0]   p_addr,
  input  logic [8*NPORT-1:0]    p_len,
  input  logic [4*NPORT-1:0]    p_wstrb,
  input  logic [32*NPORT-1:0]   p_wdata,
  output logic [NPORT-1:0]      p_addr_ok,
  output logic [NPORT-1:0]      p_data_ok,
  output logic [NPORT-1:0]      p_rlast,
  output logic [32*NPORT-1:0]   p_rdata,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_e;

  wstate_e     w_state_q;
  logic [3:0]  rd_ptr_q, wr_ptr_q;
  logic [2:0]  rd_cnt_q [NPORT];
  logic        arvalid_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [1:0]  arsize_q;
  logic        awvalid_q, wvalid_q;
  logic [3:0]  wport_q;
  logic [31:0] awaddr_q, wdata_q;
  logic [1:0]  awsize_q;
  logic [3:0]  wstrb_q;

  logic             ar_free, r_hit, b_fire, wr_pend;
  logic [NPORT-1:0] rd_dec, rd_cand, wr_cand, rd_acc, wr_acc;
  logic             rd_gnt_vld, wr_gnt_vld;
  logic [3:0]       rd_gnt, wr_gnt;
  int unsigned      ri, wi;
  logic             unused_ok;

  assign unused_ok = ^{rresp, bresp, bid};

  assign ar_free = ~arvalid_q | arready;
  assign r_hit   = rvalid & (32'(rid) < NPORT);
  assign wr_pend = (w_state_q != W_IDLE);
  assign bready  = (w_state_q == W_RESP) & ~(rvalid & (rid == wport_q));
  assign b_fire  = bvalid & bready;

  // A last beat arriving this cycle frees its credit in time for a same-cycle accept.
  always_comb begin
    for (int unsigned i = 0; i < NPORT; i++) begin
      rd_dec[i]  = r_hit && (32'(rid) == i) && rlast;
      rd_cand[i] = p_req[i] && !p_wr[i] && ar_free && !reset
                   && ((32'(rd_cnt_q[i]) < MAX_RD) || rd_dec[i])
                   && !(wr_pend && (p_addr[32*i+2 +: 30] == awaddr_q[31:2]));
      wr_cand[i] = p_req[i] && p_wr[i] && (w_state_q == W_IDLE) && !reset;
    end
  end

  always_comb begin
    rd_gnt_vld = 1'b0;
    rd_gnt     = '0;
    wr_gnt_vld = 1'b0;
    wr_gnt     = '0;
    ri         = 0;
    wi         = 0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      ri = (32'(rd_ptr_q) + k) % NPORT;
      wi = (32'(wr_ptr_q) + k) % NPORT;
      if (!rd_gnt_vld && rd_cand[ri]) begin
        rd_gnt_vld = 1'b1;
        rd_gnt     = 4'(ri);
      end
      if (!wr_gnt_vld && wr_cand[wi]) begin
        wr_gnt_vld = 1'b1;
        wr_gnt     = 4'(wi);
      end
    end
    for (int unsigned i = 0; i < NPORT; i++) begin
      rd_acc[i] = rd_gnt_vld && (32'(rd_gnt) == i);
      wr_acc[i] = wr_gnt_vld && (32'(wr_gnt) == i);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NPORT; i++) begin
      p_data_ok[i] = (r_hit && (32'(rid) == i)) || (b_fire && (32'(wport_q) == i));
      p_rlast[i]   = r_hit && (32'(rid) == i) && rlast;
    end
  end

  assign p_addr_ok = rd_acc | wr_acc;
  assign p_rdata   = {NPORT{rdata}};

  always_ff @(posedge aclk) begin
    if (reset) begin
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      rd_ptr_q  <= '0;
      for (int unsigned i = 0; i < NPORT; i++) rd_cnt_q[i] <= '0;
    end else begin
      if (rd_gnt_vld) begin
        arvalid_q <= 1'b1;
        arid_q    <= rd_gnt;
        araddr_q  <= p_addr[32*rd_gnt +: 32];
        arlen_q   <= p_len[8*rd_gnt +: 8];
        arsize_q  <= p_size[2*rd_gnt +: 2];
        rd_ptr_q  <= 4'((32'(rd_gnt) + 1) % NPORT);
      end else if (arready) begin
        arvalid_q <= 1'b0;
      end
      for (int unsigned i = 0; i < NPORT; i++) begin
        if (rd_acc[i] && !rd_dec[i])
          rd_cnt_q[i] <= rd_cnt_q[i] + 3'd1;
        else if (!rd_acc[i] && rd_dec[i] && (rd_cnt_q[i] != '0))
          rd_cnt_q[i] <= rd_cnt_q[i] - 3'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      wr_ptr_q  <= '0;
      wport_q   <= '0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: if (wr_gnt_vld) begin
          wport_q   <= wr_gnt;
          awaddr_q  <= p_addr[32*wr_gnt +: 32];
          awsize_q  <= p_size[2*wr_gnt +: 2];
          wdata_q   <= p_wdata[32*wr_gnt +: 32];
          wstrb_q   <= p_wstrb[4*wr_gnt +: 4];
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          wr_ptr_q  <= 4'((32'(wr_gnt) + 1) % NPORT);
          w_state_q <= W_SEND;
        end
        W_SEND: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || awready) && (!wvalid_q || wready)) w_state_q <= W_RESP;
        end
        W_RESP: if (b_fire) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = {1'b0, arsize_q};
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arvalid = arvalid_q;
  assign rready  = 1'b1;
  assign awid    = wport_q;
  assign awaddr  = awaddr_q;
  assign awlen   = '0;
  assign awsize  = {1'b0, awsize_q};
  assign awburst = 2'b01;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign awvalid = awvalid_q;
  assign wid     = wport_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;

endmodule
